// File: rtl/writeback_ctrl_multi.sv
// Multi-lane writeback control: per-lane STAGES-deep register pipe fanned out to active list, bypass, CSR and branch ports.
// Latency STAGES cycles; no backpressure; selective squash on recovery, full clear on flush.
`ifndef SIZE_SEQ
`define SIZE_SEQ 8
`endif
`ifndef CSR_WIDTH
`define CSR_WIDTH 32
`endif
`ifndef CSR_WIDTH_LOG
`define CSR_WIDTH_LOG 12
`endif
`ifndef SIZE_PC
`define SIZE_PC 32
`endif
`ifndef BRANCH_TYPE_LOG
`define BRANCH_TYPE_LOG 2
`endif
`ifndef SIZE_CTI_LOG
`define SIZE_CTI_LOG 4
`endif
`ifndef SIZE_ACTIVELIST_LOG
`define SIZE_ACTIVELIST_LOG 6
`endif
`ifndef SIZE_PHYSICAL_LOG
`define SIZE_PHYSICAL_LOG 7
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif

package wbctrl_pkg;
  typedef struct packed {
    logic exception;
    logic isStore;
    logic isLoad;
    logic isControl;
    logic destValid;
  } wb_flags_t;

  typedef struct packed {
    logic [`SIZE_SEQ-1:0]            seqNo;
    logic                            valid;
    logic [`SIZE_ACTIVELIST_LOG-1:0] alID;
    wb_flags_t                       flags;
    logic [`SIZE_PC-1:0]             pc;
    logic [`SIZE_PC-1:0]             nextPC;
    logic                            ctrlDir;
    logic [`BRANCH_TYPE_LOG-1:0]     ctrlType;
    logic [`SIZE_CTI_LOG-1:0]        ctiID;
    logic [`SIZE_PHYSICAL_LOG-1:0]   phyDest;
    logic [`SIZE_DATA-1:0]           destData;
    logic                            csrWrEn;
    logic [`CSR_WIDTH_LOG-1:0]       csrAddr;
    logic [`CSR_WIDTH-1:0]           csrData;
  } wb_pkt_t;

  typedef struct packed {
    logic [`SIZE_SEQ-1:0]            seqNo;
    logic                            valid;
    logic [`SIZE_ACTIVELIST_LOG-1:0] alID;
    wb_flags_t                       flags;
    logic [`SIZE_PC-1:0]             nextPC;
    logic                            actualDir;
  } ctrl_pkt_t;

  typedef struct packed {
    logic [`SIZE_PHYSICAL_LOG-1:0] tag;
    logic [`SIZE_DATA-1:0]         data;
    logic                          valid;
  } bypass_pkt_t;
endpackage

module writeback_ctrl_multi
  import wbctrl_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int STAGES    = 1,
  parameter int SEQ_W     = `SIZE_SEQ,
  parameter int CSR_LANE  = 0,
  parameter int CTRL_LANE = 0,
  parameter int CNT_W     = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flushAll_i,
  input  logic                        recoverFlag_i,
  input  logic [SEQ_W-1:0]            recoverSeqNo_i,
  input  wb_pkt_t                     wbPacket_i     [NUM_LANES],
  output ctrl_pkt_t                   ctrlPacket_o   [NUM_LANES],
  output bypass_pkt_t                 bypassPacket_o [NUM_LANES],
  output logic [`CSR_WIDTH-1:0]       csrWrData_o,
  output logic [`CSR_WIDTH_LOG-1:0]   csrWrAddr_o,
  output logic                        csrWrEn_o,
  output logic [`SIZE_PC-1:0]         exeCtrlPC_o,
  output logic [`BRANCH_TYPE_LOG-1:0] exeCtrlType_o,
  output logic                        exeCtrlValid_o,
  output logic [`SIZE_PC-1:0]         exeCtrlNPC_o,
  output logic                        exeCtrlDir_o,
  output logic [`SIZE_CTI_LOG-1:0]    exeCtiID_o,
  output logic [CNT_W-1:0]            wbCount_o
);

  wb_pkt_t          stage_q [NUM_LANES][STAGES];
  wb_pkt_t          stage_d [NUM_LANES][STAGES];
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Modular age test: a non-zero difference with a clear sign bit is younger.
  function automatic wb_pkt_t apply_kill(input wb_pkt_t p, input logic flush,
                                         input logic rec, input logic [SEQ_W-1:0] r);
    wb_pkt_t          o;
    logic [SEQ_W-1:0] d;
    o = p;
    d = p.seqNo[SEQ_W-1:0] - r;
    if (flush)
      o = '0;
    else if (rec && (d != '0) && !d[SEQ_W-1])
      o.valid = 1'b0;
    return o;
  endfunction

  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) begin
      stage_d[l][0] = apply_kill(wbPacket_i[l], flushAll_i, recoverFlag_i, recoverSeqNo_i);
      for (int k = 1; k < STAGES; k++)
        stage_d[l][k] = apply_kill(stage_q[l][k-1], flushAll_i, recoverFlag_i, recoverSeqNo_i);
    end
  end

  // Counts what is visible on the outputs, so flushes never rewind it.
  always_comb begin
    cnt_d = cnt_q;
    for (int l = 0; l < NUM_LANES; l++)
      cnt_d = cnt_d + CNT_W'(stage_q[l][STAGES-1].valid);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int l = 0; l < NUM_LANES; l++)
        for (int k = 0; k < STAGES; k++)
          stage_q[l][k] <= '0;
      cnt_q <= '0;
    end else begin
      for (int l = 0; l < NUM_LANES; l++)
        for (int k = 0; k < STAGES; k++)
          stage_q[l][k] <= stage_d[l][k];
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) begin
      ctrlPacket_o[l].seqNo     = stage_q[l][STAGES-1].seqNo;
      ctrlPacket_o[l].valid     = stage_q[l][STAGES-1].valid;
      ctrlPacket_o[l].alID      = stage_q[l][STAGES-1].alID;
      ctrlPacket_o[l].flags     = stage_q[l][STAGES-1].flags;
      ctrlPacket_o[l].nextPC    = stage_q[l][STAGES-1].nextPC;
      ctrlPacket_o[l].actualDir = stage_q[l][STAGES-1].ctrlDir;
      bypassPacket_o[l].tag     = stage_q[l][STAGES-1].phyDest;
      bypassPacket_o[l].data    = stage_q[l][STAGES-1].destData;
      bypassPacket_o[l].valid   = stage_q[l][STAGES-1].valid & stage_q[l][STAGES-1].flags.destValid;
    end
  end

  assign csrWrData_o    = stage_q[CSR_LANE][STAGES-1].csrData;
  assign csrWrAddr_o    = stage_q[CSR_LANE][STAGES-1].csrAddr;
  assign csrWrEn_o      = stage_q[CSR_LANE][STAGES-1].valid & stage_q[CSR_LANE][STAGES-1].csrWrEn;
  assign exeCtrlPC_o    = stage_q[CTRL_LANE][STAGES-1].pc;
  assign exeCtrlType_o  = stage_q[CTRL_LANE][STAGES-1].ctrlType;
  assign exeCtrlValid_o = stage_q[CTRL_LANE][STAGES-1].valid & stage_q[CTRL_LANE][STAGES-1].flags.isControl;
  assign exeCtrlNPC_o   = stage_q[CTRL_LANE][STAGES-1].nextPC;
  assign exeCtrlDir_o   = stage_q[CTRL_LANE][STAGES-1].ctrlDir;
  assign exeCtiID_o     = stage_q[CTRL_LANE][STAGES-1].ctiID;
  assign wbCount_o      = cnt_q;

endmodule

// File: tb/tb_writeback_ctrl_multi.sv
// Bench for writeback_ctrl_multi: 4 lanes, 2 stages, 8-bit seqNo, 4-bit counter, against a queue-based model.
module tb_writeback_ctrl_multi;
  import wbctrl_pkg::*;

  localparam int NL = 4;
  localparam int ST = 2;
  localparam int SW = 8;
  localparam int CW = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        rec = 1'b0;
  logic [SW-1:0] rec_seq = '0;
  wb_pkt_t     in_pkt [NL];
  ctrl_pkt_t   ctrlPacket_o [NL];
  bypass_pkt_t bypassPacket_o [NL];
  logic [31:0] csrWrData_o;
  logic [11:0] csrWrAddr_o;
  logic        csrWrEn_o;
  logic [31:0] exeCtrlPC_o;
  logic [1:0]  exeCtrlType_o;
  logic        exeCtrlValid_o;
  logic [31:0] exeCtrlNPC_o;
  logic        exeCtrlDir_o;
  logic [3:0]  exeCtiID_o;
  logic [CW-1:0] wbCount_o;

  int checks = 0;
  int failures = 0;

  wb_pkt_t mq [NL][$];
  int      mcnt = 0;

  writeback_ctrl_multi #(
    .NUM_LANES(NL), .STAGES(ST), .SEQ_W(SW), .CSR_LANE(0), .CTRL_LANE(0), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .flushAll_i(flush), .recoverFlag_i(rec),
    .recoverSeqNo_i(rec_seq), .wbPacket_i(in_pkt), .ctrlPacket_o(ctrlPacket_o),
    .bypassPacket_o(bypassPacket_o), .csrWrData_o(csrWrData_o), .csrWrAddr_o(csrWrAddr_o),
    .csrWrEn_o(csrWrEn_o), .exeCtrlPC_o(exeCtrlPC_o), .exeCtrlType_o(exeCtrlType_o),
    .exeCtrlValid_o(exeCtrlValid_o), .exeCtrlNPC_o(exeCtrlNPC_o), .exeCtrlDir_o(exeCtrlDir_o),
    .exeCtiID_o(exeCtiID_o), .wbCount_o(wbCount_o)
  );

  always #5 clk = ~clk;

  function automatic bit is_younger(int s, int r);
    int d = (s - r + 256) % 256;
    return (d >= 1) && (d <= 127);
  endfunction

  function automatic void model_reset();
    for (int l = 0; l < NL; l++) begin
      mq[l].delete();
      for (int k = 0; k < ST; k++) mq[l].push_back('0);
    end
    mcnt = 0;
  endfunction

  // Each lane is a FIFO of ST packets; kills apply to everything in flight plus the new arrival.
  function automatic void model_edge();
    int pop = 0;
    wb_pkt_t t;
    for (int l = 0; l < NL; l++) pop += int'(mq[l][0].valid);
    mcnt = (mcnt + pop) % (1 << CW);
    for (int l = 0; l < NL; l++) begin
      mq[l].push_back(in_pkt[l]);
      for (int i = 0; i < mq[l].size(); i++) begin
        t = mq[l][i];
        if (flush) t = '0;
        else if (rec && is_younger(int'(t.seqNo), int'(rec_seq))) t.valid = 1'b0;
        mq[l][i] = t;
      end
      void'(mq[l].pop_front());
    end
  endfunction

  function automatic ctrl_pkt_t exp_ctrl(int l);
    ctrl_pkt_t c = '0;
    c.seqNo = mq[l][0].seqNo; c.valid = mq[l][0].valid; c.alID = mq[l][0].alID;
    c.flags = mq[l][0].flags; c.nextPC = mq[l][0].nextPC; c.actualDir = mq[l][0].ctrlDir;
    return c;
  endfunction

  function automatic bypass_pkt_t exp_byp(int l);
    bypass_pkt_t b = '0;
    b.tag = mq[l][0].phyDest; b.data = mq[l][0].destData;
    b.valid = mq[l][0].valid & mq[l][0].flags.destValid;
    return b;
  endfunction

  function automatic wb_pkt_t rand_pkt(logic [7:0] seq, logic vld);
    wb_pkt_t p;
    p.seqNo = seq; p.valid = vld; p.alID = 6'($urandom); p.flags = 5'($urandom);
    p.pc = $urandom; p.nextPC = $urandom; p.ctrlDir = 1'($urandom);
    p.ctrlType = 2'($urandom); p.ctiID = 4'($urandom); p.phyDest = 7'($urandom);
    p.destData = $urandom; p.csrWrEn = 1'($urandom); p.csrAddr = 12'($urandom);
    p.csrData = $urandom;
    return p;
  endfunction

  task automatic clear_inputs();
    for (int l = 0; l < NL; l++) in_pkt[l] = '0;
    flush = 1'b0; rec = 1'b0; rec_seq = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_reset(); else model_edge();
    #1;
  endtask

  task automatic test_reset();
    clear_inputs(); model_reset(); reset = 1'b1;
    tick(); tick();
    checks++;
    if (wbCount_o !== '0 || ctrlPacket_o[0] !== '0 || csrWrEn_o !== 1'b0) begin
      failures++; $display("FAIL reset_init cnt=%h ctrl0=%h csren=%b exp zero", wbCount_o, ctrlPacket_o[0], csrWrEn_o);
    end
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      for (int l = 0; l < NL; l++) in_pkt[l] = rand_pkt(8'(c * 4 + l), 1'b1);
      tick();
    end
    #2 reset = 1'b1;
    #1;
    for (int l = 0; l < NL; l++) begin
      checks++;
      if (ctrlPacket_o[l] !== '0 || bypassPacket_o[l] !== '0) begin
        failures++; $display("FAIL reset_async lane%0d ctrl=%h byp=%h exp zero", l, ctrlPacket_o[l], bypassPacket_o[l]);
      end
    end
    checks++;
    if (wbCount_o !== '0 || exeCtrlValid_o !== 1'b0) begin
      failures++; $display("FAIL reset_async_cnt cnt=%h ctlv=%b exp 0", wbCount_o, exeCtrlValid_o);
    end
    clear_inputs(); model_reset(); tick(); reset = 1'b0;
    in_pkt[2] = '0;
    in_pkt[2].valid = 1'b1; in_pkt[2].seqNo = 8'd5; in_pkt[2].flags.destValid = 1'b1;
    in_pkt[2].phyDest = 7'd9; in_pkt[2].destData = 32'hABCD;
    tick(); clear_inputs();
    checks++;
    if (bypassPacket_o[2].valid !== 1'b0) begin
      failures++; $display("FAIL reset_lat_early got=%b exp=0", bypassPacket_o[2].valid);
    end
    tick();
    checks++;
    if (bypassPacket_o[2] !== {7'd9, 32'hABCD, 1'b1}) begin
      failures++; $display("FAIL reset_bypass2 got=%h exp=%h", bypassPacket_o[2], {7'd9, 32'hABCD, 1'b1});
    end
  endtask

  task automatic test_selective_recovery();
    clear_inputs();
    for (int l = 0; l < NL; l++) in_pkt[l] = rand_pkt(8'(10 + l), 1'b1);
    tick();
    clear_inputs(); rec = 1'b1; rec_seq = 8'd11;
    tick();
    rec = 1'b0;
    for (int l = 0; l < NL; l++) begin
      checks++;
      if (ctrlPacket_o[l].valid !== (l < 2) || ctrlPacket_o[l].seqNo !== 8'(10 + l)) begin
        failures++; $display("FAIL sel_recover lane%0d got v=%b s=%0d exp v=%b s=%0d",
                             l, ctrlPacket_o[l].valid, ctrlPacket_o[l].seqNo, l < 2, 10 + l);
      end
    end
  endtask

  task automatic test_wraparound();
    logic [7:0] seqs [3];
    seqs[0] = 8'hFD; seqs[1] = 8'hFE; seqs[2] = 8'h01;
    clear_inputs();
    for (int l = 0; l < 3; l++) in_pkt[l] = rand_pkt(seqs[l], 1'b1);
    tick();
    clear_inputs(); rec = 1'b1; rec_seq = 8'hFE;
    in_pkt[0] = rand_pkt(8'hFE, 1'b1);
    in_pkt[3] = rand_pkt(8'h02, 1'b1);
    tick();
    clear_inputs();
    for (int l = 0; l < 3; l++) begin
      checks++;
      if (ctrlPacket_o[l].valid !== (l < 2)) begin
        failures++; $display("FAIL wrap lane%0d seq=%h got=%b exp=%b", l, seqs[l], ctrlPacket_o[l].valid, l < 2);
      end
    end
    tick();
    checks++;
    if (ctrlPacket_o[0].valid !== 1'b1 || ctrlPacket_o[3].valid !== 1'b0 || ctrlPacket_o[3].seqNo !== 8'h02) begin
      failures++; $display("FAIL wrap_capture got v0=%b v3=%b s3=%h exp 1 0 02",
                           ctrlPacket_o[0].valid, ctrlPacket_o[3].valid, ctrlPacket_o[3].seqNo);
    end
  endtask

  task automatic test_flush_priority();
    int cnt_after;
    clear_inputs();
    for (int c = 0; c < ST; c++) begin
      for (int l = 0; l < NL; l++) in_pkt[l] = rand_pkt(8'(50 + l), 1'b1);
      tick();
    end
    flush = 1'b1; rec = 1'b1; rec_seq = 8'd40;
    for (int l = 0; l < NL; l++) in_pkt[l] = rand_pkt(8'(60 + l), 1'b1);
    tick();
    cnt_after = mcnt;
    clear_inputs();
    checks++;
    if (int'(wbCount_o) !== cnt_after) begin
      failures++; $display("FAIL flush_cnt got=%0d exp=%0d", wbCount_o, cnt_after);
    end
    for (int c = 0; c < 2; c++) begin
      for (int l = 0; l < NL; l++) begin
        checks++;
        if (ctrlPacket_o[l] !== '0 || bypassPacket_o[l] !== '0) begin
          failures++; $display("FAIL flush_clear c%0d lane%0d ctrl=%h byp=%h exp zero", c, l, ctrlPacket_o[l], bypassPacket_o[l]);
        end
      end
      tick();
    end
    checks++;
    if (int'(wbCount_o) !== cnt_after) begin
      failures++; $display("FAIL flush_cnt_hold got=%0d exp=%0d", wbCount_o, cnt_after);
    end
  endtask

  task automatic test_csr_ctrl_steering();
    clear_inputs();
    in_pkt[0] = rand_pkt(8'd70, 1'b1);
    in_pkt[0].csrWrEn = 1'b1; in_pkt[0].csrAddr = 12'h300; in_pkt[0].csrData = 32'h8;
    in_pkt[0].flags.isControl = 1'b1; in_pkt[0].nextPC = 32'h1000; in_pkt[0].ctrlDir = 1'b1;
    in_pkt[1] = rand_pkt(8'd71, 1'b1);
    in_pkt[1].csrWrEn = 1'b1; in_pkt[1].csrAddr = 12'h111; in_pkt[1].csrData = 32'h77;
    tick();
    in_pkt[0].valid = 1'b0;
    tick();
    clear_inputs();
    checks++;
    if (csrWrEn_o !== 1'b1 || csrWrAddr_o !== 12'h300 || csrWrData_o !== 32'h8) begin
      failures++; $display("FAIL csr_lane0 got en=%b a=%h d=%h exp 1 300 8", csrWrEn_o, csrWrAddr_o, csrWrData_o);
    end
    checks++;
    if (exeCtrlValid_o !== 1'b1 || exeCtrlNPC_o !== 32'h1000 || exeCtrlDir_o !== 1'b1) begin
      failures++; $display("FAIL ctrl_lane0 got v=%b npc=%h dir=%b exp 1 1000 1", exeCtrlValid_o, exeCtrlNPC_o, exeCtrlDir_o);
    end
    tick();
    checks++;
    if (csrWrEn_o !== 1'b0 || exeCtrlValid_o !== 1'b0) begin
      failures++; $display("FAIL csr_ctrl_invalid got en=%b ctlv=%b exp 0 0", csrWrEn_o, exeCtrlValid_o);
    end
  endtask

  task automatic test_counter();
    int pat [6] = '{4, 4, 4, 3, 2, 0};
    int exp_cnt [9] = '{0, 0, 0, 4, 8, 12, 15, 1, 1};
    clear_inputs(); reset = 1'b1; tick(); reset = 1'b0;
    for (int t = 1; t <= 8; t++) begin
      clear_inputs();
      if (t <= 6)
        for (int l = 0; l < pat[t-1]; l++) in_pkt[l] = rand_pkt(8'(t), 1'b1);
      tick();
      checks++;
      if (int'(wbCount_o) !== exp_cnt[t]) begin
        failures++; $display("FAIL counter t%0d got=%0d exp=%0d", t, wbCount_o, exp_cnt[t]);
      end
    end
    clear_inputs();
  endtask

  task automatic test_random();
    logic [7:0] base = 8'hE0;
    for (int c = 0; c < 400; c++) begin
      base = base + 8'($urandom_range(0, 3));
      for (int l = 0; l < NL; l++)
        in_pkt[l] = rand_pkt(base + 8'($urandom_range(0, 12)), 1'($urandom_range(0, 3) != 0));
      flush = ($urandom_range(0, 23) == 0);
      rec = ($urandom_range(0, 5) == 0);
      rec_seq = base + 8'($urandom_range(0, 12));
      tick();
      for (int l = 0; l < NL; l++) begin
        checks++;
        if (ctrlPacket_o[l] !== exp_ctrl(l)) begin
          failures++; $display("FAIL rand_ctrl c%0d lane%0d got=%h exp=%h", c, l, ctrlPacket_o[l], exp_ctrl(l));
        end
        checks++;
        if (bypassPacket_o[l] !== exp_byp(l)) begin
          failures++; $display("FAIL rand_byp c%0d lane%0d got=%h exp=%h", c, l, bypassPacket_o[l], exp_byp(l));
        end
      end
      checks++;
      if (csrWrEn_o !== (mq[0][0].valid & mq[0][0].csrWrEn) || csrWrAddr_o !== mq[0][0].csrAddr ||
          csrWrData_o !== mq[0][0].csrData) begin
        failures++; $display("FAIL rand_csr c%0d got en=%b a=%h d=%h exp en=%b a=%h d=%h", c, csrWrEn_o, csrWrAddr_o,
                             csrWrData_o, mq[0][0].valid & mq[0][0].csrWrEn, mq[0][0].csrAddr, mq[0][0].csrData);
      end
      checks++;
      if (exeCtrlValid_o !== (mq[0][0].valid & mq[0][0].flags.isControl) || exeCtrlPC_o !== mq[0][0].pc ||
          exeCtrlNPC_o !== mq[0][0].nextPC || exeCtrlDir_o !== mq[0][0].ctrlDir ||
          exeCtrlType_o !== mq[0][0].ctrlType || exeCtiID_o !== mq[0][0].ctiID) begin
        failures++; $display("FAIL rand_exectrl c%0d got v=%b pc=%h npc=%h exp v=%b pc=%h npc=%h", c, exeCtrlValid_o,
                             exeCtrlPC_o, exeCtrlNPC_o, mq[0][0].valid & mq[0][0].flags.isControl, mq[0][0].pc, mq[0][0].nextPC);
      end
      checks++;
      if (int'(wbCount_o) !== mcnt) begin
        failures++; $display("FAIL rand_cnt c%0d got=%0d exp=%0d", c, wbCount_o, mcnt);
      end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_selective_recovery();
    test_wraparound();
    test_flush_priority();
    test_csr_ctrl_steering();
    test_counter();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
